// File: rtl/mem_access_ctrl_if.sv
//==============================================================================
// Module      : mem_access_ctrl_if
// Description : Data-bus bundle between mem_access_ctrl (master) and the
//               data memory / interconnect (slave). One req/gnt handshake
//               per access, then a single rvalid beat for loads.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_access_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic                  dbus_req;
  logic                  dbus_we;
  logic [ADDR_W-1:0]     dbus_addr;
  logic [DATA_W/8-1:0]   dbus_be;
  logic [DATA_W-1:0]     dbus_wdata;
  logic                  dbus_gnt;
  logic                  dbus_rvalid;
  logic [DATA_W-1:0]     dbus_rdata;

  // Controller side: issues requests, receives grant and read data.
  modport master (
    output dbus_req,
    output dbus_we,
    output dbus_addr,
    output dbus_be,
    output dbus_wdata,
    input  dbus_gnt,
    input  dbus_rvalid,
    input  dbus_rdata
  );

  // Memory side: accepts requests, returns grant and read data.
  modport slave (
    input  dbus_req,
    input  dbus_we,
    input  dbus_addr,
    input  dbus_be,
    input  dbus_wdata,
    output dbus_gnt,
    output dbus_rvalid,
    output dbus_rdata
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//==============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage data-bus controller. Converts the load/store held in
//               the MEM pipeline register into one dbus req/gnt(/rvalid)
//               transaction, stalls MEM until it completes, then aligns and
//               sign/zero-extends load data for WB.
// Config      : MEM_MISALIGN_TRAP_EN - when defined, a misaligned access goes
//               straight to DONE with misalign_fault=1 and no bus request.
//               When undefined, the low address bits covered by the access
//               size are forced to zero and the access proceeds.
// Notes       : DATA_W must be at least 64 so a doubleword fits in one beat.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  // MEM pipeline register
  input  wire logic              mem_valid,
  input  wire logic              mem_is_load,
  input  wire logic              mem_is_store,
  input  wire logic [ADDR_W-1:0] mem_addr,
  input  wire logic [1:0]        mem_size,
  input  wire logic              mem_sign_ext,
  input  wire logic [DATA_W-1:0] mem_wdata,
  // traffic_control
  input  wire logic              mem_wr_en,
  input  wire logic              flush_before_wb,
  output logic                   mem_stall,
  // data bus
  mem_access_ctrl_if.master      dbus,
  // WB-side results
  output logic [DATA_W-1:0]      ld_data,
  output logic                   misalign_fault
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // ---------------------------------------------------------------------------
  // State and registered bus outputs
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              fault_q, fault_d;
  logic              latch_en;

  // A bubble, or a valid non-memory instruction, is not an access.
  logic access;
  assign access = mem_valid & (mem_is_load | mem_is_store);

  // ---------------------------------------------------------------------------
  // Request formatting from the MEM register fields
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]  size_off_mask;   // address bits that must be 0 for alignment
  logic [BE_W-1:0]   size_be;         // right-justified byte enables
  logic [DATA_W-1:0] size_data_mask;  // right-justified store data mask

  // Decode the access size into alignment, byte-enable and data masks.
  always_comb begin
    size_off_mask  = '0;
    size_be        = '0;
    size_data_mask = '0;
    case (mem_size)
      2'd0: begin
        size_off_mask  = OFF_W'(0);
        size_be        = BE_W'(8'h01);
        size_data_mask = DATA_W'(64'h0000_0000_0000_00FF);
      end
      2'd1: begin
        size_off_mask  = OFF_W'(1);
        size_be        = BE_W'(8'h03);
        size_data_mask = DATA_W'(64'h0000_0000_0000_FFFF);
      end
      2'd2: begin
        size_off_mask  = OFF_W'(3);
        size_be        = BE_W'(8'h0F);
        size_data_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      end
      default: begin
        size_off_mask  = OFF_W'(7);
        size_be        = BE_W'(8'hFF);
        size_data_mask = DATA_W'(64'hFFFF_FFFF_FFFF_FFFF);
      end
    endcase
  end

  // Lane offset with the size-covered low bits cleared; when trapping is
  // enabled a misaligned access never reaches the bus, so clearing is harmless.
  logic [OFF_W-1:0]  lane_off;
  logic [ADDR_W-1:0] bus_addr;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata;

  assign lane_off   = mem_addr[OFF_W-1:0] & ~size_off_mask;
  assign bus_addr   = {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign lane_be    = size_be << lane_off;
  assign lane_wdata = (mem_wdata & size_data_mask) << {lane_off, 3'b000};

  logic trap_now;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_now = |(mem_addr[OFF_W-1:0] & size_off_mask);
`else
  assign trap_now = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_ext;

  assign rd_shift = dbus.dbus_rdata >> {off_q, 3'b000};

  // Extend the lane-extracted load value to the full data width.
  always_comb begin
    ld_ext = rd_shift;
    case (size_q)
      2'd0:    ld_ext = {{(DATA_W-8){sext_q & rd_shift[7]}},   rd_shift[7:0]};
      2'd1:    ld_ext = {{(DATA_W-16){sext_q & rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    ld_ext = {{(DATA_W-32){sext_q & rd_shift[31]}}, rd_shift[31:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; flush has priority but never abandons a granted access
  // ---------------------------------------------------------------------------
  // Compute next state, request, result and fault values.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ld_data_d = ld_data_q;
    fault_d   = fault_q;
    latch_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush_before_wb && access) begin
          if (trap_now) begin
            state_d = S_DONE;
            fault_d = 1'b1;
          end else begin
            state_d  = S_REQ;
            req_d    = 1'b1;
            latch_en = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (dbus.dbus_gnt) begin
          // Granted: the access happens regardless of flush.
          req_d = 1'b0;
          if (flush_before_wb) begin
            state_d = we_q ? S_IDLE : S_DRAIN;
          end else begin
            state_d = we_q ? S_DONE : S_WAIT;
          end
        end else if (flush_before_wb) begin
          // Withdrawal before grant is legal on this bus.
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (dbus.dbus_rvalid) begin
          // Data arriving in the flush cycle completes the transaction, so
          // there is nothing left to drain; it is simply discarded.
          if (flush_before_wb) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DONE;
            ld_data_d = ld_ext;
          end
        end else if (flush_before_wb) begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        if (flush_before_wb || mem_wr_en) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (dbus.dbus_rvalid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Registers; async clear returns a mid-transaction controller to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      size_q    <= 2'd0;
      sext_q    <= 1'b0;
      ld_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ld_data_q <= ld_data_d;
      fault_q   <= fault_d;
      if (latch_en) begin
        we_q    <= mem_is_store & ~mem_is_load;
        addr_q  <= bus_addr;
        be_q    <= lane_be;
        wdata_q <= lane_wdata;
        off_q   <= lane_off;
        size_q  <= mem_size;
        sext_q  <= mem_sign_ext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_be    = be_q;
  assign dbus.dbus_wdata = wdata_q;

  // DONE is the only state in which a pending access lets MEM advance; in
  // DRAIN this holds any new access back until the old read has returned.
  // Held low while reset is asserted.
  assign mem_stall      = reset_n & access & (state_q != S_DONE);
  assign ld_data        = ld_data_q;
  assign misalign_fault = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
//==============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl: table of accesses
//               with a bus responder and scoreboard, plus flush/drain/reset
//               sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_is_load, mem_is_store, mem_sign_ext;
  logic [63:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_wr_en, flush_before_wb;
  logic        mem_stall, misalign_fault;
  logic [63:0] ld_data;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(64), .DATA_W(64)) dbus_if ();

  mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_valid       (mem_valid),
    .mem_is_load     (mem_is_load),
    .mem_is_store    (mem_is_store),
    .mem_addr        (mem_addr),
    .mem_size        (mem_size),
    .mem_sign_ext    (mem_sign_ext),
    .mem_wdata       (mem_wdata),
    .mem_wr_en       (mem_wr_en),
    .flush_before_wb (flush_before_wb),
    .mem_stall       (mem_stall),
    .dbus            (dbus_if),
    .ld_data         (ld_data),
    .misalign_fault  (misalign_fault)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [63:0] wdata;
    int          gnt_wait;   // REQ cycles without grant before the granted one
    logic [63:0] rdata;
    logic [63:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wlane;    // store data within enabled lanes
    logic [63:0] e_ld;
    int          e_stalls;
    logic        e_fault;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  vec_t exp_q [$];
  vec_t dv;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lanes(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (be[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one access, act as the bus slave, and check it end to end.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int   req_cycles = 0;
    int   stalls = 0;
    bit   done = 1'b0;
    bit   pend = 1'b0;
    mem_valid    = 1'b1;
    mem_is_load  = v.ld;
    mem_is_store = v.st;
    mem_addr     = v.addr;
    mem_size     = v.size;
    mem_sign_ext = v.sext;
    mem_wdata    = v.wdata;
    mem_wr_en    = 1'b0;
    dbus_if.dbus_gnt    = 1'b0;
    dbus_if.dbus_rvalid = 1'b0;
    if (!v.e_fault) exp_q.push_back(v);
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) tick();
      dbus_if.dbus_gnt    = 1'b0;
      dbus_if.dbus_rvalid = 1'b0;
      if (pend) begin
        dbus_if.dbus_rvalid = 1'b1;
        dbus_if.dbus_rdata  = v.rdata;
        pend = 1'b0;
      end
      if (mem_stall) stalls++;
      else done = 1'b1;
      if (dbus_if.dbus_req) begin
        if (req_cycles == v.gnt_wait) begin
          dbus_if.dbus_gnt = 1'b1;
          if (exp_q.size() == 0) begin
            check({tag, "_unexpected_req"}, 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check({tag, "_addr"}, dbus_if.dbus_addr, e.e_addr);
            check({tag, "_be"}, {56'd0, dbus_if.dbus_be}, {56'd0, e.e_be});
            check({tag, "_we"}, {63'd0, dbus_if.dbus_we}, {63'd0, e.st});
            if (e.st) check({tag, "_wdata"}, dbus_if.dbus_wdata & lanes(e.e_be), e.e_wlane);
          end
          if (v.ld) pend = 1'b1;
        end
        req_cycles++;
      end
    end
    check({tag, "_completed"}, {63'd0, done}, 64'd1);
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(v.e_stalls));
    check({tag, "_req_cycles"}, 64'(req_cycles), v.e_fault ? 64'd0 : 64'(v.gnt_wait + 1));
    check({tag, "_fault"}, {63'd0, misalign_fault}, {63'd0, v.e_fault});
    check({tag, "_req_in_done"}, {63'd0, dbus_if.dbus_req}, 64'd0);
    if (v.ld && !v.e_fault) check({tag, "_ld_data"}, ld_data, v.e_ld);
    mem_wr_en = 1'b1;
    tick();
    mem_wr_en    = 1'b0;
    mem_valid    = 1'b0;
    mem_is_load  = 1'b0;
    mem_is_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          ld    st    addr          sz    sx    wdata                   gw rdata                   e_addr        e_be   e_wlane                 e_ld                    st fault
    vecs[0]  = '{1'b1, 1'b0, 64'h1004, 2'd2, 1'b1, 64'h0,                  1, 64'h8000_0001_0000_0000, 64'h1000, 8'hF0, 64'h0,                  64'hFFFF_FFFF_8000_0001, 4, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 64'h2003, 2'd0, 1'b0, 64'hAB,                 0, 64'h0,                  64'h2000, 8'h08, 64'h0000_0000_AB00_0000, 64'h0,                  2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'h3005, 2'd0, 1'b0, 64'h0,                  0, 64'h0011_9922_3344_5566, 64'h3000, 8'h20, 64'h0,                  64'h0000_0000_0000_0099, 3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 64'h3005, 2'd0, 1'b1, 64'h0,                  0, 64'h0011_9922_3344_5566, 64'h3000, 8'h20, 64'h0,                  64'hFFFF_FFFF_FFFF_FF99, 3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 64'h4006, 2'd1, 1'b1, 64'h0,                  0, 64'h8123_0000_0000_0000, 64'h4000, 8'hC0, 64'h0,                  64'hFFFF_FFFF_FFFF_8123, 3, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 64'h5008, 2'd3, 1'b0, 64'h0,                  3, 64'hDEAD_BEEF_0123_4567, 64'h5008, 8'hFF, 64'h0,                  64'hDEAD_BEEF_0123_4567, 6, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 64'h6000, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 2, 64'h0,                  64'h6000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                  4, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 64'h7002, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF, 0, 64'h0,                  64'h7000, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0,                  2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 64'h8000, 2'd2, 1'b0, 64'h0,                  0, 64'h1234_5678_9ABC_DEF0, 64'h8000, 8'h0F, 64'h0,                  64'h0000_0000_9ABC_DEF0, 3, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[9]  = '{1'b1, 1'b0, 64'h1001, 2'd1, 1'b0, 64'h0,                  0, 64'h0000_0000_0000_F00D, 64'h0,    8'h00, 64'h0,                  64'h0,                  1, 1'b1};
`else
    vecs[9]  = '{1'b1, 1'b0, 64'h1001, 2'd1, 1'b0, 64'h0,                  0, 64'h0000_0000_0000_F00D, 64'h1000, 8'h03, 64'h0,                  64'h0000_0000_0000_F00D, 3, 1'b0};
`endif
    vecs[10] = '{1'b1, 1'b0, 64'h7FF2, 2'd1, 1'b1, 64'h0,                  0, 64'h0000_0000_7FFF_0000, 64'h7FF0, 8'h0C, 64'h0,                  64'h0000_0000_0000_7FFF, 3, 1'b0};

    // Reset, with an access presented: everything must read zero.
    reset_n = 1'b0;
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_is_store = 1'b0;
    mem_addr = 64'h0; mem_size = 2'd0; mem_sign_ext = 1'b0; mem_wdata = 64'h0;
    mem_wr_en = 1'b0; flush_before_wb = 1'b0;
    dbus_if.dbus_gnt = 1'b0; dbus_if.dbus_rvalid = 1'b0; dbus_if.dbus_rdata = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {63'd0, dbus_if.dbus_req}, 64'd0);
    check("rst_stall", {63'd0, mem_stall}, 64'd0);
    check("rst_ld",    ld_data, 64'd0);
    check("rst_fault", {63'd0, misalign_fault}, 64'd0);
    mem_valid = 1'b0; mem_is_load = 1'b0;
    reset_n = 1'b1;
    tick();

    // A bubble carrying load flags never stalls or issues.
    mem_is_load = 1'b1;
    tick();
    tick();
    check("bubble_stall", {63'd0, mem_stall}, 64'd0);
    check("bubble_req",   {63'd0, dbus_if.dbus_req}, 64'd0);
    mem_is_load = 1'b0;

    // Table, issued back to back.
    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush in REQ without grant: request withdrawn next cycle.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_addr = 64'h9000; mem_size = 2'd3;
    tick();
    check("rqf_req_on", {63'd0, dbus_if.dbus_req}, 64'd1);
    flush_before_wb = 1'b1;
    tick();
    flush_before_wb = 1'b0; mem_valid = 1'b0; mem_is_load = 1'b0;
    #1;
    check("rqf_req_off", {63'd0, dbus_if.dbus_req}, 64'd0);
    check("rqf_stall",   {63'd0, mem_stall}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rqf_idle%0d", k), {63'd0, dbus_if.dbus_req}, 64'd0);
    end
    run_vec(vecs[8], "after_rqf");

    // Flush in WAIT: drain the outstanding read before the next load issues.
    dv = '{1'b1, 1'b0, 64'hB014, 2'd2, 1'b0, 64'h0, 0, 64'h5555_6666_7777_8888,
           64'hB010, 8'hF0, 64'h0, 64'h0000_0000_5555_6666, 3, 1'b0};
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_addr = 64'hA000; mem_size = 2'd3; mem_sign_ext = 1'b0;
    tick();
    check("drn_req_on", {63'd0, dbus_if.dbus_req}, 64'd1);
    dbus_if.dbus_gnt = 1'b1;
    tick();
    dbus_if.dbus_gnt = 1'b0;
    check("drn_wait_req", {63'd0, dbus_if.dbus_req}, 64'd0);
    flush_before_wb = 1'b1;
    tick();
    flush_before_wb = 1'b0;
    mem_addr = dv.addr; mem_size = dv.size; mem_sign_ext = dv.sext;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drn_stall%0d", k), {63'd0, mem_stall}, 64'd1);
      check($sformatf("drn_noreq%0d", k), {63'd0, dbus_if.dbus_req}, 64'd0);
      tick();
    end
    dbus_if.dbus_rvalid = 1'b1;
    dbus_if.dbus_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    check("drn_stall_rv", {63'd0, mem_stall}, 64'd1);
    tick();
    dbus_if.dbus_rvalid = 1'b0;
    run_vec(dv, "post_drain");

    // Reset while waiting for read data: outputs clear at once.
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_addr = 64'hC000; mem_size = 2'd3;
    tick();
    dbus_if.dbus_gnt = 1'b1;
    tick();
    dbus_if.dbus_gnt = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rwt_req",   {63'd0, dbus_if.dbus_req}, 64'd0);
    check("rwt_stall", {63'd0, mem_stall}, 64'd0);
    check("rwt_addr",  dbus_if.dbus_addr, 64'd0);
    check("rwt_be",    {56'd0, dbus_if.dbus_be}, 64'd0);
    check("rwt_ld",    ld_data, 64'd0);
    check("rwt_fault", {63'd0, misalign_fault}, 64'd0);
    mem_valid = 1'b0; mem_is_load = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(vecs[6], "after_reset");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
